msrv32_dmem_responder: RTL and testbench
========================================

# msrv32_dmem_responder

Single-port data-memory responder on the slave end of the core's AHB-style data interface. It accepts address-phase requests from the core's store/load path, performs byte-masked writes and word reads on an internal word array, and returns read data, HREADY and HRESP. Wait states are configurable and out-of-range addresses get a two-cycle ERROR response. Sits between the core's data-memory ports and the SoC as the default data RAM and as the bench model for load/store tests.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, minimum 2.
- BASE_ADDRESS, 32'h0000_0000: byte address of word 0; word-aligned.
- WAIT_STATES, 0: HREADY-low cycles inserted per data phase; range 0..15.

Ports:
- clock  in  1  sole clock; all state changes on its rising edge.
- rst_in  in  1  reset, asynchronous, active-high.
- dmaddr_in  in  32  byte address, valid in the address phase.
- dmdata_in  in  32  write data, presented in the same cycle as the address.
- dmwr_req_in  in  1  1 = write, 0 = read.
- dmwr_mask_in  in  4  byte-lane write enables; bit i covers data[8i+7:8i].
- htrans_in  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- data_out  out  32  read data, valid when hready_out=1 in a completing read data phase.
- hready_out  out  1  1 = current data phase completes / new address accepted.
- hresp_out  out  1  0 OKAY, 1 ERROR.

## Operation
- Transfer request: htrans_in[1]=1 (NONSEQ or SEQ, treated identically). IDLE and BUSY are never accepted.
- Acceptance: a request is sampled on a rising edge only while the state is READY. On acceptance, capture the address, dmwr_req_in, dmwr_mask_in and dmdata_in.
- Range check: in_range = (addr >= BASE_ADDRESS) and (addr - BASE_ADDRESS < 4*DEPTH_WORDS). Computed 33 bits wide so there is no wrap-around at 32'hFFFF_FFFC.
- Index: (addr - BASE_ADDRESS)[log2(DEPTH_WORDS)+1:2]. addr[1:0] is ignored; alignment checking belongs to the core.
- States:
  - READY: hready_out=1, hresp_out=0.
    - Accepted in-range request with WAIT_STATES=0: access performed at the acceptance edge; stay READY.
    - Accepted in-range request with WAIT_STATES>0: go to WAIT with cnt=WAIT_STATES-1.
    - Accepted out-of-range request: go to ERR1.
  - WAIT: hready_out=0, hresp_out=0.
    - cnt>0: decrement cnt.
    - cnt=0: perform the access and go to READY.
  - ERR1: hready_out=0, hresp_out=1; always go to ERR2.
  - ERR2: hready_out=1, hresp_out=1. Any request presented in this cycle is dropped (not accepted); go to READY.
- Access:
  - Write: update only the lanes whose mask bit is 1. Mask 0000 is a legal no-op with an OKAY response.
  - Read: register mem[index] into data_out.
  - data_out holds its value until the next read access; writes and errors do not change it.
- Errored transfers never modify memory. data_out is unchanged on an error.
- Read-after-write to the same word, back-to-back, returns the new data.
- Memory contents are not reset.

## Timing
- Reset (asynchronous assert, clocked release): state=READY, cnt=0, data_out=32'h0, hready_out=1, hresp_out=0.
- Reset mid-WAIT or mid-ERR returns to READY immediately. A pending write is dropped.
- Address phase in cycle N. The data phase completes (hready_out=1) in cycle N+1+WAIT_STATES. Read data is valid in that same cycle.
- With WAIT_STATES=0 the block is fully pipelined: one transfer per cycle, and the address of transfer k+1 overlaps the data phase of transfer k.
- With WAIT_STATES>0, throughput is one transfer per WAIT_STATES+1 cycles. Requests presented while hready_out=0 are not sampled; the core must hold them.
- Error: hready_out=0/hresp_out=1 in cycle N+1, then hready_out=1/hresp_out=1 in cycle N+2. The earliest next acceptance is in cycle N+3.
- hready_out and hresp_out are decoded from state only, with no combinational path from the inputs.

## Test plan
- Reset with WAIT_STATES=0 → data_out=0, hready_out=1, hresp_out=0. Write 32'hDEAD_BEEF to 0x10 with mask 1111, then read 0x10 → data_out=32'hDEAD_BEEF in the cycle after the read address, hresp_out=0.
- Byte lanes: word 0x20 = 32'h1122_3344; write 32'hAABB_CCDD with mask 0101 → read returns 32'h11BB_33DD. Mask 0000 write → word unchanged.
- WAIT_STATES=3: read at cycle N → hready_out low in N+1..N+3 and high in N+4 with valid data. A second request held during the wait is accepted in N+4.
- Out-of-range write (BASE_ADDRESS + 4*DEPTH_WORDS) → ERR1/ERR2 sequence, request presented during ERR2 ignored, memory unchanged, data_out unchanged. Address 32'hFFFF_FFFC with BASE_ADDRESS=0 → ERROR, no wrap.
- Back-to-back with WAIT_STATES=0: write 0x4 = 5 then immediately read 0x4, then read 0x8 → data 5, then mem[2], on consecutive cycles with hready_out=1 throughout.
- Assert rst_in in the second WAIT cycle of a write → outputs take reset values immediately and the target word keeps its old value.

Source files
------------

// File: rtl/msrv32_dmem_responder.sv
// Data-memory slave for the core's AHB-style data port: byte-masked writes, registered word
// reads, configurable wait states and a two-cycle ERROR response for out-of-range addresses.
module msrv32_dmem_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int unsigned WAIT_STATES  = 0
) (
  input  logic        clock,
  input  logic        rst_in,
  input  logic [31:0] dmaddr_in,
  input  logic [31:0] dmdata_in,
  input  logic        dmwr_req_in,
  input  logic [3:0]  dmwr_mask_in,
  input  logic [1:0]  htrans_in,
  output logic [31:0] data_out,
  output logic        hready_out,
  output logic        hresp_out
);

  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] Span     = 33'(DEPTH_WORDS) << 2;
  localparam bit          HasWait  = (WAIT_STATES > 0);
  localparam logic [3:0]  WaitInit = HasWait ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {StReady, StWait, StErr1, StErr2} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q;
  logic              wr_q;
  logic [3:0]        mask_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem [DEPTH_WORDS];

  logic [32:0]       offset;
  logic              in_range;
  logic              req;
  logic [IdxW-1:0]   idx_in;
  logic              capture;
  logic              acc_en;
  logic [IdxW-1:0]   acc_idx;
  logic              acc_wr;
  logic [3:0]        acc_mask;
  logic [31:0]       acc_wdata;
  logic              unused_htrans;

  // 33-bit subtraction: bit 32 set means the address is below the base, and the top of the
  // address space cannot wrap back into range.
  assign offset        = {1'b0, dmaddr_in} - {1'b0, BASE_ADDRESS};
  assign in_range      = !offset[32] && (offset < Span);
  assign idx_in        = offset[IdxW+1:2];
  assign req           = htrans_in[1];
  assign unused_htrans = htrans_in[0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    acc_en    = 1'b0;
    acc_idx   = idx_q;
    acc_wr    = wr_q;
    acc_mask  = mask_q;
    acc_wdata = wdata_q;
    unique case (state_q)
      StReady: begin
        if (req) begin
          if (!in_range) begin
            state_d = StErr1;
          end else if (HasWait) begin
            state_d = StWait;
            cnt_d   = WaitInit;
            capture = 1'b1;
          end else begin
            acc_en    = 1'b1;
            acc_idx   = idx_in;
            acc_wr    = dmwr_req_in;
            acc_mask  = dmwr_mask_in;
            acc_wdata = dmdata_in;
          end
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          acc_en  = 1'b1;
          state_d = StReady;
        end
      end
      StErr1:  state_d = StErr2;
      StErr2:  state_d = StReady;
      default: state_d = StReady;
    endcase
    // The memory array has no reset, so a pending write must be blocked while reset is held.
    if (rst_in) acc_en = 1'b0;
  end

  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StReady;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      mask_q  <= 4'd0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        idx_q   <= idx_in;
        wr_q    <= dmwr_req_in;
        mask_q  <= dmwr_mask_in;
        wdata_q <= dmdata_in;
      end
      if (acc_en && !acc_wr) rdata_q <= mem[acc_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (acc_en && acc_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_mask[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    hready_out = 1'b1;
    hresp_out  = 1'b0;
    unique case (state_q)
      StReady: begin hready_out = 1'b1; hresp_out = 1'b0; end
      StWait:  begin hready_out = 1'b0; hresp_out = 1'b0; end
      StErr1:  begin hready_out = 1'b0; hresp_out = 1'b1; end
      StErr2:  begin hready_out = 1'b1; hresp_out = 1'b1; end
      default: begin hready_out = 1'b1; hresp_out = 1'b0; end
    endcase
  end

  assign data_out = rdata_q;

endmodule

// File: tb/tb_msrv32_dmem_responder.sv
// Scoreboard bench: one zero-wait responder and one three-wait responder with an offset base.
module tb_msrv32_dmem_responder;

  typedef struct {
    bit          err;
    logic [31:0] data;
    int          lat;
    int          acc;
  } item_t;

  logic        clock = 1'b0;
  logic        rst0, rst3;
  logic [31:0] addr, wdata;
  logic        wr;
  logic [3:0]  mask;
  logic [1:0]  htrans0, htrans3;
  logic [31:0] data0, data3;
  logic        rdy0, rdy3, resp0, resp3;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  item_t       expq [2][$];
  item_t       infl [2][$];
  logic [31:0] last [2];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  msrv32_dmem_responder #(
    .DEPTH_WORDS(1024), .BASE_ADDRESS(32'h0000_0000), .WAIT_STATES(0)
  ) dut0 (
    .clock(clock), .rst_in(rst0), .dmaddr_in(addr), .dmdata_in(wdata), .dmwr_req_in(wr),
    .dmwr_mask_in(mask), .htrans_in(htrans0), .data_out(data0), .hready_out(rdy0),
    .hresp_out(resp0)
  );

  msrv32_dmem_responder #(
    .DEPTH_WORDS(16), .BASE_ADDRESS(32'h0000_1000), .WAIT_STATES(3)
  ) dut3 (
    .clock(clock), .rst_in(rst3), .dmaddr_in(addr), .dmdata_in(wdata), .dmwr_req_in(wr),
    .dmwr_mask_in(mask), .htrans_in(htrans3), .data_out(data3), .hready_out(rdy3),
    .hresp_out(resp3)
  );

  function automatic void chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", nm, d, act, exp, cyc);
    end
  endfunction

  function automatic logic rdy_of(int d);
    return (d == 0) ? rdy0 : rdy3;
  endfunction

  function automatic logic resp_of(int d);
    return (d == 0) ? resp0 : resp3;
  endfunction

  // Monitor: retires a data phase whenever hready is high, then records any new acceptance.
  task automatic mon(input int d, input logic rst, input logic [1:0] tr, input logic rdy,
                     input logic resp, input logic [31:0] dat);
    item_t it;
    if (rst) return;
    if (infl[d].size() > 0) begin
      if (rdy) begin
        it = infl[d].pop_front();
        chk("latency", d, cyc - it.acc, it.lat);
        chk("hresp", d, {31'h0, resp}, {31'h0, it.err});
        chk("data_out", d, dat, it.data);
      end else begin
        chk("wait_hresp", d, {31'h0, resp}, {31'h0, infl[d][0].err});
        if (cyc - infl[d][0].acc > 20) begin
          total++;
          bad++;
          $display("FAIL completion_timeout dut%0d: no hready after %0d cycles", d, 20);
          infl[d].delete();
        end
      end
    end
    if (tr[1] && rdy && !resp) begin
      if (expq[d].size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_accept dut%0d: accepted with nothing queued", d);
      end else begin
        it = expq[d].pop_front();
        it.acc = cyc;
        infl[d].push_back(it);
      end
    end
  endtask

  always @(negedge clock) begin
    mon(0, rst0, htrans0, rdy0, resp0, data0);
    mon(1, rst3, htrans3, rdy3, resp3, data3);
  end

  // Presents one request and holds it until accepted; returns the acceptance cycle.
  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] wd, input logic w,
                       input logic [3:0] m, input bit err, input logic [31:0] rexp,
                       output int acc);
    item_t it;
    logic ok;
    it.err = err;
    it.lat = err ? 2 : ((d == 0) ? 1 : 4);
    it.acc = 0;
    if (!w && !err) last[d] = rexp;
    it.data = last[d];
    expq[d].push_back(it);
    addr = a; wdata = wd; wr = w; mask = m;
    if (d == 0) htrans0 = 2'b10; else htrans3 = 2'b10;
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      ok = rdy_of(d) && !resp_of(d);
      if (ok) acc = cyc;
      @(posedge clock); #1;
      if (ok) break;
    end
    if (acc < 0) begin
      total++;
      bad++;
      $display("FAIL accept_timeout dut%0d: request at %h never accepted", d, a);
    end
  endtask

  task automatic idle();
    htrans0 = 2'b00;
    htrans3 = 2'b00;
    @(posedge clock); #1;
  endtask

  initial begin
    int a1, a2;
    rst0 = 1'b1; rst3 = 1'b1;
    addr = 32'h0; wdata = 32'h0; wr = 1'b0; mask = 4'h0;
    htrans0 = 2'b00; htrans3 = 2'b00;
    last[0] = 32'h0; last[1] = 32'h0;
    repeat (2) @(negedge clock);
    chk("rst_hready", 0, {31'h0, rdy0}, 32'h1);
    chk("rst_hresp", 0, {31'h0, resp0}, 32'h0);
    chk("rst_data", 0, data0, 32'h0);
    chk("rst_hready", 1, {31'h0, rdy3}, 32'h1);
    rst0 = 1'b0; rst3 = 1'b0;
    @(posedge clock); #1;

    // Zero-wait: basic write then read.
    issue(0, 32'h10, 32'hDEAD_BEEF, 1'b1, 4'hF, 1'b0, 32'h0, a1);
    idle();
    issue(0, 32'h10, 32'h0, 1'b0, 4'h0, 1'b0, 32'hDEAD_BEEF, a1);
    idle();

    // Byte lanes, including the empty mask, back-to-back.
    issue(0, 32'h20, 32'h1122_3344, 1'b1, 4'hF, 1'b0, 32'h0, a1);
    issue(0, 32'h20, 32'hAABB_CCDD, 1'b1, 4'h5, 1'b0, 32'h0, a1);
    issue(0, 32'h20, 32'h0, 1'b0, 4'h0, 1'b0, 32'h11BB_33DD, a1);
    issue(0, 32'h20, 32'hFFFF_FFFF, 1'b1, 4'h0, 1'b0, 32'h0, a1);
    issue(0, 32'h20, 32'h0, 1'b0, 4'h0, 1'b0, 32'h11BB_33DD, a1);
    idle();

    // Out-of-range write aliasing word 0; a write offered only during ERR2 must be dropped.
    issue(0, 32'h0, 32'h0BAD_F00D, 1'b1, 4'hF, 1'b0, 32'h0, a1);
    idle();
    issue(0, 32'h1000, 32'h0, 1'b1, 4'hF, 1'b1, 32'h0, a1);
    htrans0 = 2'b00;
    @(posedge clock); #1;
    addr = 32'h10; wdata = 32'h0; wr = 1'b1; mask = 4'hF; htrans0 = 2'b10;
    @(posedge clock); #1;
    idle();
    issue(0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0BAD_F00D, a1);
    issue(0, 32'h10, 32'h0, 1'b0, 4'h0, 1'b0, 32'hDEAD_BEEF, a1);
    idle();
    issue(0, 32'hFFFF_FFFC, 32'h0, 1'b0, 4'h0, 1'b1, 32'h0, a1);
    idle();
    idle();

    // Fully pipelined write/read/read.
    issue(0, 32'h8, 32'h1234_5678, 1'b1, 4'hF, 1'b0, 32'h0, a1);
    idle();
    issue(0, 32'h4, 32'h5, 1'b1, 4'hF, 1'b0, 32'h0, a1);
    issue(0, 32'h4, 32'h0, 1'b0, 4'h0, 1'b0, 32'h5, a1);
    issue(0, 32'h8, 32'h0, 1'b0, 4'h0, 1'b0, 32'h1234_5678, a1);
    idle();

    // Three wait states: the held read is accepted four cycles after the write.
    issue(1, 32'h1004, 32'hCAFE_F00D, 1'b1, 4'hF, 1'b0, 32'h0, a1);
    issue(1, 32'h1004, 32'h0, 1'b0, 4'h0, 1'b0, 32'hCAFE_F00D, a2);
    chk("held_accept", 1, a2 - a1, 32'd4);
    idle();
    issue(1, 32'h0FFC, 32'h0, 1'b0, 4'h0, 1'b1, 32'h0, a1);
    idle();
    idle();
    issue(1, 32'h1040, 32'h0, 1'b1, 4'hF, 1'b1, 32'h0, a1);
    idle();
    idle();
    repeat (6) idle();

    // Reset in the second wait cycle of a write.
    issue(1, 32'h1004, 32'h0, 1'b1, 4'hF, 1'b0, 32'h0, a1);
    htrans3 = 2'b00;
    @(posedge clock); #1;
    rst3 = 1'b1;
    #1;
    chk("midwait_rst_hready", 1, {31'h0, rdy3}, 32'h1);
    chk("midwait_rst_hresp", 1, {31'h0, resp3}, 32'h0);
    chk("midwait_rst_data", 1, data3, 32'h0);
    infl[1].delete();
    expq[1].delete();
    last[1] = 32'h0;
    @(posedge clock);
    @(negedge clock);
    rst3 = 1'b0;
    @(posedge clock); #1;
    issue(1, 32'h1004, 32'h0, 1'b0, 4'h0, 1'b0, 32'hCAFE_F00D, a1);
    idle();

    repeat (10) @(posedge clock);
    #1;
    chk("drained", 0, infl[0].size() + expq[0].size(), 32'd0);
    chk("drained", 1, infl[1].size() + expq[1].size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
